btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner_pkg.sv | 17 +
 rtl/btn_channel.sv | 116 +++++++++++
 rtl/btn_conditioner.sv | 40 ++++
 tb/tb_btn_conditioner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_conditioner_pkg.sv
// Shared definitions for the button front end: repeat FSM encodings and
// default timing for a 125 MHz system clock.
package btn_conditioner_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   localparam int unsigned CLK_HZ = 125_000_000;

   // 10 ms debounce, 500 ms to first repeat, 200 ms between repeats
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_250_000;
   localparam int unsigned DEF_REPEAT_DELAY    = 62_500_000;
   localparam int unsigned DEF_REPEAT_RATE     = 25_000_000;
   localparam int unsigned DEF_CNT_W           = 27;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// strobes and the auto-repeat FSM.
module btn_channel
   import btn_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic held_o
);

   localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   logic [1:0]       sync_q;
   logic             s;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] rp_cnt_q, rp_cnt_d;
   logic             rise, fall, rep_fire;
   logic [CNT_W-1:0] rp_last;

   assign s = sync_q[1];

   always_comb begin
      level_d  = level_q;
      db_cnt_d = '0;
      if (s != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = s;
         end else begin
            db_cnt_d = db_cnt_q + CNT_ONE;
         end
      end
   end

   assign rise    = level_d & ~level_q;
   assign fall    = ~level_d & level_q;
   assign rp_last = (state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST;

   // A release always wins over a repeat that would have fired this cycle.
   always_comb begin
      state_d  = state_q;
      rp_cnt_d = rp_cnt_q;
      rep_fire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d  = ST_DELAY;
               rp_cnt_d = '0;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            if (fall) begin
               state_d  = ST_IDLE;
               rp_cnt_d = '0;
            end else if (!repeat_en_i) begin
               rp_cnt_d = '0;
            end else if (rp_cnt_q == rp_last) begin
               rep_fire = 1'b1;
               rp_cnt_d = '0;
               state_d  = ST_REPEAT;
            end else begin
               rp_cnt_d = rp_cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            rp_cnt_d = '0;
         end
      endcase
   end

   assign press_d   = rise | rep_fire;
   assign release_d = fall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q    <= '0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         state_q   <= ST_IDLE;
         rp_cnt_q  <= '0;
      end else begin
         sync_q    <= {sync_q[0], btn_i};
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         state_q   <= state_d;
         rp_cnt_q  <= rp_cnt_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign held_o    = (state_q == ST_REPEAT);

endmodule

// File: rtl/btn_conditioner.sv
// Per-button conditioning for the traffic-light controller: N_BTN independent
// channels producing debounced levels and press/release/repeat strobes.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int unsigned N_BTN           = 3,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_BTN-1:0] btn_i,
   input  logic [N_BTN-1:0] repeat_en_i,
   output logic [N_BTN-1:0] level_o,
   output logic [N_BTN-1:0] press_o,
   output logic [N_BTN-1:0] release_o,
   output logic [N_BTN-1:0] held_o
);

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .btn_i       (btn_i[g]),
         .repeat_en_i (repeat_en_i[g]),
         .level_o     (level_o[g]),
         .press_o     (press_o[g]),
         .release_o   (release_o[g]),
         .held_o      (held_o[g])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus randomized button traffic
// compared against a cycle-level behavioural model.
module tb_btn_conditioner;

   localparam int N    = 3;
   localparam int DB   = 4;
   localparam int RD   = 10;
   localparam int RR   = 3;
   localparam int CW   = 8;
   localparam int LOGN = 2048;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] btn = '0;
   logic [N-1:0] en = '0;
   logic [N-1:0] level, press, rel, held;

   always #5 clk = ~clk;

   btn_conditioner #(
      .N_BTN           (N),
      .DEBOUNCE_CYCLES (DB),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR),
      .CNT_W           (CW)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .btn_i       (btn),
      .repeat_en_i (en),
      .level_o     (level),
      .press_o     (press),
      .release_o   (rel),
      .held_o      (held)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [N-1:0] pr_log [LOGN];
   logic [N-1:0] rl_log [LOGN];
   logic [N-1:0] hd_log [LOGN];
   logic [N-1:0] lv_log [LOGN];

   // Reference model: input samples, run length of disagreement, repeat timer
   logic [N-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl, m_hd, m_arm;
   int           m_run [N];
   int           m_el  [N];

   task automatic model_step();
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pr = '0; m_rl = '0; m_hd = '0; m_arm = '0;
         for (int c = 0; c < N; c++) begin
            m_run[c] = 0;
            m_el[c]  = 0;
         end
         return;
      end
      for (int c = 0; c < N; c++) begin
         logic s;
         logic old;
         s   = m_s2[c];
         old = m_lvl[c];
         m_s2[c] = m_s1[c];
         m_s1[c] = btn[c];
         m_pr[c] = 1'b0;
         m_rl[c] = 1'b0;
         if (s != old) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               m_lvl[c] = s;
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
         if (old && !m_lvl[c]) begin
            m_rl[c] = 1'b1; m_arm[c] = 1'b0; m_hd[c] = 1'b0; m_el[c] = 0;
         end else if (!old && m_lvl[c]) begin
            m_pr[c] = 1'b1; m_arm[c] = 1'b1; m_el[c] = 0;
         end else if (m_arm[c]) begin
            if (!en[c]) begin
               m_el[c] = 0;
            end else begin
               m_el[c]++;
               if (m_el[c] == (m_hd[c] ? RR : RD)) begin
                  m_pr[c] = 1'b1; m_hd[c] = 1'b1; m_el[c] = 0;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < LOGN) begin
         pr_log[cyc] = press; rl_log[cyc] = rel; hd_log[cyc] = held; lv_log[cyc] = level;
      end
      chk("level", 32'(level), 32'(m_lvl));
      chk("press", 32'(press), 32'(m_pr));
      chk("release", 32'(rel), 32'(m_rl));
      chk("held", 32'(held), 32'(m_hd));
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int base;
      logic any1;
      logic [1:0] tog [7];
      tog = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0};

      // Reset state
      ticks(3);
      chk("rst_outputs", 32'({level, press, rel, held}), 32'd0);
      rst_n = 1'b1;
      ticks(3);

      // 1: single press and release, no repeat
      en = '0;
      btn[0] = 1'b1;
      base = cyc;
      ticks(20);
      btn[0] = 1'b0;
      ticks(10);
      for (int k = 1; k <= 30; k++) begin
         chk("s1_press", 32'(pr_log[base+k][0]), 32'(k == 6));
         chk("s1_release", 32'(rl_log[base+k][0]), 32'(k == 26));
         chk("s1_level", 32'(lv_log[base+k][0]), 32'(k >= 6 && k < 26));
      end

      // 2: bouncing input never qualifies
      base = cyc;
      for (int i = 0; i < 7; i++) begin
         btn[1] = tog[i][0];
         tick();
      end
      btn[1] = 1'b0;
      ticks(10);
      any1 = 1'b0;
      for (int k = 1; k <= 17; k++) any1 = any1 | lv_log[base+k][1] | pr_log[base+k][1] | rl_log[base+k][1];
      chk("s2_bounce", 32'(any1), 32'd0);

      // 3: auto-repeat cadence and held window
      en[0] = 1'b1;
      btn[0] = 1'b1;
      base = cyc;
      ticks(30);
      btn[0] = 1'b0;
      ticks(10);
      for (int k = 1; k <= 40; k++) begin
         chk("s3_press", 32'(pr_log[base+k][0]),
             32'((k == 6) || (k >= 16 && k <= 34 && (k - 16) % 3 == 0)));
         chk("s3_held", 32'(hd_log[base+k][0]), 32'(k >= 16 && k < 36));
      end

      // 4: simultaneous presses on two channels
      en = '0;
      btn = 3'b101;
      base = cyc;
      ticks(8);
      chk("s4_before", 32'(pr_log[base+5]), 32'd0);
      chk("s4_press", 32'(pr_log[base+6]), 32'b101);
      chk("s4_after", 32'(pr_log[base+7]), 32'd0);
      btn = '0;
      ticks(8);

      // 5: asynchronous reset while repeating, button still held
      en[0] = 1'b1;
      btn[0] = 1'b1;
      ticks(20);
      chk("s5_in_repeat", 32'(held[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_async_clear", 32'({level, press, rel, held}), 32'd0);
      ticks(2);
      rst_n = 1'b1;
      base = cyc;
      ticks(20);
      for (int k = 1; k <= 20; k++)
         chk("s5_press", 32'(pr_log[base+k][0]), 32'(k == 6 || k == 16 || k == 19));

      // 6: repeat enable dropped for 7 cycles while repeating
      en[0] = 1'b0;
      ticks(7);
      en[0] = 1'b1;
      ticks(5);
      for (int k = 21; k <= 30; k++) begin
         chk("s6_press", 32'(pr_log[base+k][0]), 32'(k == 30));
         chk("s6_held", 32'(hd_log[base+k][0]), 32'd1);
      end
      btn = '0;
      en = '0;
      ticks(10);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 9) == 0) btn[c] = ~btn[c];
         if ($urandom_range(0, 19) == 0) en = N'($urandom);
         rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      rst_n = 1'b1;
      ticks(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
